// File: rtl/prog_ctr_pkg.sv
// Shared definitions for the program-sequencing slice: FSM states, default
// widths, ALU opcodes and the branch-target ROM image.
package prog_ctr_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int IDX_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_SHR = 4'd6,
    ALU_BGE = 4'd7,
    ALU_BNE = 4'd8,
    ALU_BEQ = 4'd9
  } alu_op_e;

  // Branch-target image, same contents as branch_lut.hex: entry i = (i+1)*16.
  function automatic logic [31:0] lut_entry(input logic [31:0] idx);
    return (idx + 32'd1) << 4;
  endfunction

endpackage

// File: rtl/prog_ctr_branch_lut.sv
// Combinational branch-target ROM, 2**IDX_W entries of PC_W bits.
module branch_lut
  import prog_ctr_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [IDX_W-1:0] idx,
  output logic [PC_W-1:0]  target
);

  logic [PC_W-1:0] rom [2**IDX_W];

  for (genvar i = 0; i < 2**IDX_W; i++) begin : g_rom
    assign rom[i] = PC_W'(lut_entry(32'(i)));
  end

  assign target = rom[idx];

endmodule

// File: rtl/prog_ctr.sv
// Program counter sequencer: start/run/halt control, LUT-driven branches and
// a saturating retired-instruction counter.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for Start; PC and count hold
// ST_RUN  | one instruction retired per cycle; PC steps or branches
// ST_HALT | program halted, Done high; leaves once Start is dropped
module prog_ctr
  import prog_ctr_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             BranchEn,
  input  logic             BranchFlag,
  input  logic [IDX_W-1:0] BranchIdx,
  input  logic             HaltIn,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);

  pc_state_e        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;
  logic [PC_W-1:0]  branch_target;

  branch_lut #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_lut (
    .idx    (BranchIdx),
    .target (branch_target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          pc_d    = StartAddr;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // Halt wins over a taken branch; BranchFlag only matters when enabled.
        if (HaltIn)                      state_d = ST_HALT;
        else if (BranchEn && BranchFlag) pc_d    = branch_target;
        else                             pc_d    = pc_q + PC_W'(1);
      end
      ST_HALT: begin
        if (!Start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == ST_HALT);
    end
  end

  assign ProgCtr    = pc_q;
  assign InstrCount = cnt_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Directed bench for prog_ctr with hand-computed expected values.
module tb_prog_ctr;

  localparam int PC_W  = 10;
  localparam int IDX_W = 5;
  localparam int CNT_W = 4;   // narrow counter so saturation is reachable quickly

  logic             Clk = 1'b0;
  logic             Reset, Start, BranchEn, BranchFlag, HaltIn;
  logic [PC_W-1:0]  StartAddr;
  logic [IDX_W-1:0] BranchIdx;
  logic [PC_W-1:0]  ProgCtr;
  logic             Done;
  logic [CNT_W-1:0] InstrCount;

  int errors = 0;
  int checks = 0;

  prog_ctr #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .BranchEn   (BranchEn),
    .BranchFlag (BranchFlag),
    .BranchIdx  (BranchIdx),
    .HaltIn     (HaltIn),
    .ProgCtr    (ProgCtr),
    .Done       (Done),
    .InstrCount (InstrCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                            input logic d);
    check({tag, ".pc"}, 32'(ProgCtr), pc);
    check({tag, ".cnt"}, 32'(InstrCount), cnt);
    check({tag, ".done"}, 32'(Done), 32'(d));
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; StartAddr = '0; BranchEn = 1'b0;
    BranchFlag = 1'b0; BranchIdx = '0; HaltIn = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    expect_all("reset", 32'h000, 0, 1'b0);

    // Idle holds; StartAddr alone does nothing
    StartAddr = 10'h123;
    tick(); tick();
    expect_all("idle_hold", 32'h000, 0, 1'b0);

    // Basic run from 0x010
    Start = 1'b1; StartAddr = 10'h010;
    tick();
    Start = 1'b0;
    expect_all("run0", 32'h010, 0, 1'b0);
    tick(); expect_all("run1", 32'h011, 1, 1'b0);
    tick(); expect_all("run2", 32'h012, 2, 1'b0);
    tick(); expect_all("run3", 32'h013, 3, 1'b0);

    // Branch taken to LUT[3] = 0x040
    BranchEn = 1'b1; BranchFlag = 1'b1; BranchIdx = 5'd3;
    tick(); expect_all("br_taken", 32'h040, 4, 1'b0);
    BranchFlag = 1'b0;
    tick(); expect_all("br_not_taken", 32'h041, 5, 1'b0);
    BranchEn = 1'b0; BranchFlag = 1'bx;
    tick(); expect_all("br_disabled", 32'h042, 6, 1'b0);
    BranchFlag = 1'b1; BranchIdx = 5'd7;
    tick(); expect_all("flag_no_en", 32'h043, 7, 1'b0);

    // Start in RUN is ignored
    Start = 1'b1; StartAddr = 10'h2AA;
    tick(); expect_all("start_in_run", 32'h044, 8, 1'b0);
    Start = 1'b0;

    // Branch to another entry: LUT[7] = 0x080
    BranchEn = 1'b1; BranchFlag = 1'b1; BranchIdx = 5'd7;
    tick(); expect_all("br_idx7", 32'h080, 9, 1'b0);

    // Halt together with a taken branch: halt wins
    HaltIn = 1'b1; BranchIdx = 5'd3;
    tick(); expect_all("halt", 32'h080, 10, 1'b1);
    HaltIn = 1'b0; BranchEn = 1'b0; BranchFlag = 1'b0; Start = 1'b1;
    tick(); expect_all("halt_hold_start", 32'h080, 10, 1'b1);
    tick(); expect_all("halt_hold_start2", 32'h080, 10, 1'b1);
    Start = 1'b0;
    tick(); expect_all("halt_release", 32'h080, 10, 1'b0);
    tick(); expect_all("idle_after_halt", 32'h080, 10, 1'b0);

    // Wrap-around at the top of the address space
    Start = 1'b1; StartAddr = 10'h3FE;
    tick(); Start = 1'b0;
    expect_all("wrap0", 32'h3FE, 0, 1'b0);
    tick(); expect_all("wrap1", 32'h3FF, 1, 1'b0);
    tick(); expect_all("wrap2", 32'h000, 2, 1'b0);
    tick(); expect_all("wrap3", 32'h001, 3, 1'b0);

    // Reset mid-RUN at 0x055, with Start also asserted
    Reset = 1'b1;
    tick(); Reset = 1'b0;
    Start = 1'b1; StartAddr = 10'h053;
    tick(); Start = 1'b0;
    tick(); tick();
    expect_all("pre_reset", 32'h055, 2, 1'b0);
    Reset = 1'b1; Start = 1'b1; BranchEn = 1'b1; BranchFlag = 1'b1; HaltIn = 1'b1;
    tick();
    Reset = 1'b0; Start = 1'b0; BranchEn = 1'b0; BranchFlag = 1'b0; HaltIn = 1'b0;
    expect_all("mid_run_reset", 32'h000, 0, 1'b0);
    tick(); expect_all("post_reset_idle", 32'h000, 0, 1'b0);

    // Fresh start from IDLE, then run long enough to saturate the counter
    Start = 1'b1; StartAddr = 10'h200;
    tick(); Start = 1'b0;
    expect_all("sat_start", 32'h200, 0, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    expect_all("sat_14", 32'h20E, 14, 1'b0);
    tick(); expect_all("sat_15", 32'h20F, 15, 1'b0);
    tick(); expect_all("sat_16", 32'h210, 15, 1'b0);
    tick(); expect_all("sat_17", 32'h211, 15, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
